jk_updown_counter: RTL and testbench

JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

---
 rtl/jk_updown_counter_pkg.sv | 19 +
 rtl/jk_updown_counter_ffjk.sv | 31 +++
 rtl/jk_updown_counter.sv | 105 ++++++++++
 tb/tb_jk_updown_counter.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/jk_updown_counter_pkg.sv
// Shared constants and types for the JK up/down counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package jk_updown_counter_pkg;

  // Counter width: default value and the legal range.
  localparam int JKC_WIDTH_DEFAULT = 4;
  localparam int JKC_WIDTH_MIN     = 2;
  localparam int JKC_WIDTH_MAX     = 8;

  // Per-edge operation, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    JKC_HOLD = 2'b00,
    JKC_UP   = 2'b01,
    JKC_DOWN = 2'b10,
    JKC_LOAD = 2'b11
  } jkc_op_t;

endpackage : jk_updown_counter_pkg

// File: rtl/jk_updown_counter_ffjk.sv
// Single JK flip-flop cell with a clock enable and asynchronous active-high clear.
// Latency: q updates one clk edge after j/k are sampled.
// Backpressure: none; the cell captures on every enabled edge.
module jk_updown_counter_ffjk (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  logic r_q;

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else if (i_en) begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q = r_q;

endmodule : jk_updown_counter_ffjk

// File: rtl/jk_updown_counter.sv
// Up/down counter built from JK flip-flops, with parallel load, terminal count and wrap pulse.
// Latency: Q and Wrap register on the next clk edge; TC is combinational from Q, Up and En.
// Backpressure: none; Load and En are sampled on every rising edge.
module jk_updown_counter
  import jk_updown_counter_pkg::*;
#(
  parameter int WIDTH = JKC_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             Wrap
);

  jkc_op_t          w_op;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_ones_below;
  logic [WIDTH-1:0] w_zeros_below;
  logic             w_all_ones;
  logic             w_all_zeros;
  logic             r_wrap;

  // Select this edge's operation: Load beats count, count beats hold.
  always_comb begin
    w_op = JKC_HOLD;
    if (Load) begin
      w_op = JKC_LOAD;
    end else if (En) begin
      w_op = Up ? JKC_UP : JKC_DOWN;
    end
  end

  // Toggle conditions per bit: all lower bits 1 (up) or all lower bits 0 (down).
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix
    if (gi == 0) begin : g_lsb
      assign w_ones_below[gi]  = 1'b1;
      assign w_zeros_below[gi] = 1'b1;
    end else begin : g_upper
      assign w_ones_below[gi]  = &w_q[gi-1:0];
      assign w_zeros_below[gi] = ~|w_q[gi-1:0];
    end
  end

  // J/K excitation; enable gating lives here so the cells can run ungated.
  always_comb begin
    w_j = '0;
    w_k = '0;
    case (w_op)
      JKC_LOAD: begin
        w_j = D;
        w_k = ~D;
      end
      JKC_UP: begin
        w_j = w_ones_below;
        w_k = w_ones_below;
      end
      JKC_DOWN: begin
        w_j = w_zeros_below;
        w_k = w_zeros_below;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  // One JK cell per state bit, cell enable tied high.
  for (genvar gb = 0; gb < WIDTH; gb++) begin : g_bit
    jk_updown_counter_ffjk u_ffjk (
      .i_clk (clk),
      .i_rst (reset),
      .i_en  (1'b1),
      .i_j   (w_j[gb]),
      .i_k   (w_k[gb]),
      .o_q   (w_q[gb])
    );
  end

  assign w_all_ones  = &w_q;
  assign w_all_zeros = ~|w_q;

  // Terminal count reacts to Up/En in the same cycle; it is still valid from Q=0 during reset.
  assign TC = En & (Up ? w_all_ones : w_all_zeros);

  // Wrap pulses for the cycle after a counting edge taken at terminal count; a load suppresses it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= TC & ~Load;
    end
  end

  assign Q    = w_q;
  assign Wrap = r_wrap;

endmodule : jk_updown_counter

// File: tb/tb_jk_updown_counter.sv
// Randomized and directed bench for jk_updown_counter against an arithmetic reference model.
// Latency: checks Q/Wrap one edge after each stimulus, TC in the same cycle.
// Backpressure: n/a.
module tb_jk_updown_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         reset;
  logic         En;
  logic         Up;
  logic         Load;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         TC;
  logic         Wrap;

  int n_checks;
  int n_pass;
  int model_q;
  int model_wrap;

  jk_updown_counter #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .En    (En),
    .Up    (Up),
    .Load  (Load),
    .D     (D),
    .Q     (Q),
    .TC    (TC),
    .Wrap  (Wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_tc(input int q, input bit en, input bit up);
    if (!en) return 0;
    if (up) return (q == M - 1) ? 1 : 0;
    return (q == 0) ? 1 : 0;
  endfunction

  // Called at posedge+1: apply inputs, check TC, take an edge, check Q and Wrap.
  task automatic cycle(input bit en, input bit up, input bit ld, input int d);
    int exp_tc;
    En   = en;
    Up   = up;
    Load = ld;
    D    = d[W-1:0];
    #1;
    exp_tc = model_tc(model_q, en, up);
    chk("tc", int'(TC), exp_tc);
    model_wrap = (exp_tc == 1 && !ld) ? 1 : 0;
    if (ld)       model_q = d % M;
    else if (en)  model_q = up ? (model_q + 1) % M : (model_q + M - 1) % M;
    @(posedge clk);
    #1;
    chk("q", int'(Q), model_q);
    chk("wrap", int'(Wrap), model_wrap);
  endtask

  // Called at posedge+1: assert reset between edges, hold it for n edges with junk inputs.
  task automatic do_reset(input int n);
    reset = 1'b1;
    #1;
    model_q    = 0;
    model_wrap = 0;
    chk("rst_q_async", int'(Q), 0);
    chk("rst_wrap_async", int'(Wrap), 0);
    for (int i = 0; i < n; i++) begin
      En   = 1'($urandom);
      Up   = 1'($urandom);
      Load = 1'($urandom);
      D    = W'($urandom);
      #1;
      chk("rst_tc", int'(TC), model_tc(0, En, Up));
      @(posedge clk);
      #1;
      chk("rst_q_hold", int'(Q), 0);
      chk("rst_wrap_hold", int'(Wrap), 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    model_q    = 0;
    model_wrap = 0;
    reset = 1'b1;
    En    = 1'b0;
    Up    = 1'b0;
    Load  = 1'b0;
    D     = '0;
    @(posedge clk);
    #1;
    chk("reset_q", int'(Q), 0);
    chk("reset_wrap", int'(Wrap), 0);
    chk("reset_tc_idle", int'(TC), 0);
    En = 1'b1;
    Up = 1'b0;
    #1;
    chk("reset_tc_down", int'(TC), 1);
    @(posedge clk);
    #1;
    chk("reset_q_ignores_en", int'(Q), 0);
    do_reset(2);

    // Full up-count from reset, wrapping 15 -> 0.
    for (int i = 0; i < M; i++) cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);

    // Down-count from reset: 0 -> 15 -> 14.
    do_reset(1);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // Load overrides a disabled counter, then hold.
    cycle(0, 0, 1, 5);
    cycle(0, 0, 1, 10);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);

    // Load at terminal count suppresses Wrap.
    cycle(0, 0, 1, M - 1);
    cycle(1, 1, 1, 3);

    // Load of the current value at terminal count.
    cycle(0, 0, 1, M - 1);
    cycle(1, 1, 1, M - 1);

    // Direction flip with no dead cycle: 7 -> 8 -> 7 -> 6.
    cycle(0, 0, 1, 7);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);

    // Reset mid-count at 9, then resume from 0.
    cycle(0, 0, 1, 8);
    cycle(1, 1, 0, 0);
    do_reset(1);
    cycle(1, 1, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        do_reset(int'($urandom_range(1, 2)));
      end else begin
        cycle(($urandom_range(0, 9) < 8), 1'($urandom),
              ($urandom_range(0, 99) < 15), int'($urandom_range(0, M - 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_jk_updown_counter
